// File: rtl/commu_pkg.sv
// Shared definitions for the commu serial link.
// Used by the transmitter here and the receiver on the master FPGA.
package commu_pkg;

  localparam int COMMU_WORD_W  = 16;
  localparam int COMMU_BIT_W   = $clog2(COMMU_WORD_W);
  localparam int COMMU_BIT_CYC = 8;
  localparam int COMMU_GAP_CYC = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/commu_bit_tmr.sv
// Bit-period cycle counter for the commu transmitter.
// Gives the bit-end strobe and the next-cycle tx_clk level.
module commu_bit_tmr #(
  parameter int BIT_CYC = 8
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic bit_end,
  output logic clk_hi_nxt
);

  localparam int CW = $clog2(BIT_CYC);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign bit_end = run && (cnt == CW'(BIT_CYC - 1));

  always_comb begin
    cnt_nxt = cnt;
    if (start) begin
      cnt_nxt = '0;
    end else if (run) begin
      cnt_nxt = bit_end ? '0 : cnt + 1'b1;
    end
  end

  // Outputs are registered downstream, so expose the level of the next cycle.
  assign clk_hi_nxt = (cnt_nxt >= CW'(BIT_CYC / 2));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/commu_tx.sv
// commu serial word transmitter: 16-bit word, MSB first,
// on a source-synchronous frame/clock/data link.
module commu_tx
  import commu_pkg::*;
#(
  parameter int BIT_CYC = COMMU_BIT_CYC,
  parameter int GAP_CYC = COMMU_GAP_CYC
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        fire_tx,
  input  logic [15:0] data_tx,
  output logic        done_tx,
  output logic        busy,
  output logic        fire_err,
  output logic        tx_frm,
  output logic        tx_clk,
  output logic        tx_dat
);

  localparam int GW = $clog2(GAP_CYC + 1);

  tx_state_t                 state;
  tx_state_t                 nxt;
  logic [COMMU_WORD_W-1:0]   sreg;
  logic [COMMU_WORD_W-1:0]   sreg_nxt;
  logic [COMMU_BIT_W-1:0]    bit_cnt;
  logic [GW-1:0]             gap_cnt;
  logic                      start;
  logic                      run;
  logic                      bit_end;
  logic                      clk_hi_nxt;
  logic                      last_bit;

  assign start    = (state == IDLE) && fire_tx;
  assign run      = (state == SHIFT);
  assign last_bit = (bit_cnt == COMMU_BIT_W'(COMMU_WORD_W - 1));

  commu_bit_tmr #(
    .BIT_CYC (BIT_CYC)
  ) u_tmr (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .start      (start),
    .run        (run),
    .bit_end    (bit_end),
    .clk_hi_nxt (clk_hi_nxt)
  );

  always_comb begin
    nxt      = state;
    sreg_nxt = sreg;
    unique case (state)
      IDLE: begin
        if (fire_tx) begin
          nxt      = SHIFT;
          sreg_nxt = data_tx;
        end
      end
      SHIFT: begin
        if (bit_end) begin
          sreg_nxt = {sreg[COMMU_WORD_W-2:0], 1'b0};
          if (last_bit) nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYC - 1)) nxt = DONE;
      end
      DONE: begin
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      done_tx  <= 1'b0;
      busy     <= 1'b0;
      fire_err <= 1'b0;
      tx_frm   <= 1'b0;
      tx_clk   <= 1'b0;
      tx_dat   <= 1'b0;
    end else begin
      state <= nxt;
      sreg  <= sreg_nxt;
      if (start) begin
        bit_cnt <= '0;
      end else if (bit_end && !last_bit) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      gap_cnt  <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      // Link outputs follow the next state so they line up with it.
      done_tx  <= (nxt == DONE);
      busy     <= (nxt != IDLE);
      fire_err <= fire_err | (fire_tx && (state != IDLE));
      tx_frm   <= (nxt == SHIFT);
      tx_clk   <= (nxt == SHIFT) && clk_hi_nxt;
      tx_dat   <= (nxt == SHIFT) && sreg_nxt[COMMU_WORD_W-1];
    end
  end

endmodule

// File: tb/tb_commu_tx.sv
// Scoreboard bench for commu_tx: default timing and a
// BIT_CYC=2 / GAP_CYC=1 instance.
module tb_commu_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fire_a, fire_b;
  logic [15:0] data_a, data_b;
  logic        done_a, busy_a, err_a, frm_a, sclk_a, dat_a;
  logic        done_b, busy_b, err_b, frm_b, sclk_b, dat_b;

  commu_tx u_dut_a (
    .clk_sys  (clk),
    .rst_n    (rst_n),
    .fire_tx  (fire_a),
    .data_tx  (data_a),
    .done_tx  (done_a),
    .busy     (busy_a),
    .fire_err (err_a),
    .tx_frm   (frm_a),
    .tx_clk   (sclk_a),
    .tx_dat   (dat_a)
  );

  commu_tx #(
    .BIT_CYC (2),
    .GAP_CYC (1)
  ) u_dut_b (
    .clk_sys  (clk),
    .rst_n    (rst_n),
    .fire_tx  (fire_b),
    .data_tx  (data_b),
    .done_tx  (done_b),
    .busy     (busy_b),
    .fire_err (err_b),
    .tx_frm   (frm_b),
    .tx_clk   (sclk_b),
    .tx_dat   (dat_b)
  );

  typedef struct {
    logic [15:0] d;
    int          f;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   done_cnt_a = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor for the default-timing instance
  logic [15:0] rx_a;
  int          nb_a, fl_a, fall_a;
  logic        pclk_a, pfrm_a;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rx_a = '0; nb_a = 0; fl_a = 0;
      pclk_a = 1'b0; pfrm_a = 1'b0;
    end else begin
      if (frm_a && sclk_a && !pclk_a) begin
        rx_a = {rx_a[14:0], dat_a};
        nb_a++;
      end
      if (frm_a) fl_a++;
      if (pfrm_a && !frm_a) fall_a = cyc;
      if (done_a) begin
        done_cnt_a++;
        if (qa.size() == 0) begin
          check("spurious_done_a", 1, 0);
        end else begin
          e = qa.pop_front();
          check("word_a", {16'h0, rx_a}, {16'h0, e.d});
          check("bits_a", nb_a, 16);
          check("frm_len_a", fl_a, 128);
          check("done_lat_a", cyc - e.f, 133);
          check("gap_a", cyc - fall_a, 4);
        end
        rx_a = '0; nb_a = 0; fl_a = 0;
      end
      pclk_a = sclk_a;
      pfrm_a = frm_a;
    end
  end

  // Monitor for the fast instance
  logic [15:0] rx_b;
  int          fl_b;
  logic        pclk_b;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rx_b = '0; fl_b = 0; pclk_b = 1'b0;
    end else begin
      if (frm_b && sclk_b && !pclk_b) rx_b = {rx_b[14:0], dat_b};
      if (frm_b) fl_b++;
      if (done_b) begin
        if (qb.size() == 0) begin
          check("spurious_done_b", 1, 0);
        end else begin
          e = qb.pop_front();
          check("word_b", {16'h0, rx_b}, {16'h0, e.d});
          check("frm_len_b", fl_b, 32);
          check("done_lat_b", cyc - e.f, 34);
        end
        rx_b = '0; fl_b = 0;
      end
      pclk_b = sclk_b;
    end
  end

  task automatic fire_word(logic [15:0] d);
    fire_a = 1'b1;
    data_a = d;
    qa.push_back('{d, cyc});
    @(negedge clk);
    fire_a = 1'b0;
    data_a = 16'h0;
  endtask

  task automatic wait_done(int lim);
    int k = 0;
    while (!done_a && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (!done_a) check("done_timeout", 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int bad_clk;
    int bad_dat;
    rst_n  = 1'b0;
    fire_a = 1'b0; data_a = '0;
    fire_b = 1'b0; data_b = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", {done_a, busy_a, err_a, frm_a, sclk_a, dat_a}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", {done_a, busy_a, err_a, frm_a, sclk_a, dat_a}, 0);

    // Single word
    fire_word(16'hA5C3);
    check("busy_frm_f1", {busy_a, frm_a, sclk_a, dat_a}, 4'b1101);
    wait_done(300);
    @(negedge clk);
    check("busy_low", busy_a, 0);

    // Back-to-back, second fire in the cycle after done
    fire_word(16'h0001);
    wait_done(300);
    @(negedge clk);
    check("busy_low_b2b", busy_a, 0);
    fire_word(16'hFFFF);
    wait_done(300);
    @(negedge clk);
    check("err_clear_b2b", err_a, 0);

    // Collision at bit 5
    fire_word(16'hBEEF);
    repeat (42) @(negedge clk);
    fire_a = 1'b1;
    data_a = 16'h1234;
    @(negedge clk);
    fire_a = 1'b0;
    data_a = 16'h0;
    check("err_set", err_a, 1);
    n0 = done_cnt_a;
    wait_done(300);
    @(negedge clk);
    check("single_done", done_cnt_a - n0, 1);
    repeat (150) @(negedge clk);
    check("no_extra_done", done_cnt_a - n0, 1);
    check("err_sticky", err_a, 1);

    // Reset during bit 9
    fire_word(16'hFFFF);
    repeat (74) @(negedge clk);
    check("pre_rst_frm", {frm_a, busy_a}, 2'b11);
    #2 rst_n = 1'b0;
    qa.delete();
    #1;
    check("rst_async", {frm_a, sclk_a, dat_a, busy_a}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("err_rst", err_a, 0);
    n0 = done_cnt_a;
    repeat (200) @(negedge clk);
    check("no_done_after_rst", done_cnt_a - n0, 0);

    // Fire in the done cycle
    fire_word(16'h5A5A);
    wait_done(300);
    fire_a = 1'b1;
    data_a = 16'h1111;
    @(negedge clk);
    fire_a = 1'b0;
    data_a = 16'h0;
    check("fire_in_done_ignored", {busy_a, frm_a}, 0);
    check("fire_in_done_err", err_a, 1);
    n0 = done_cnt_a;
    repeat (150) @(negedge clk);
    check("no_done_fire_in_done", done_cnt_a - n0, 0);

    // Fast instance, 16'h8000
    fire_b = 1'b1;
    data_b = 16'h8000;
    qb.push_back('{16'h8000, cyc});
    @(negedge clk);
    fire_b = 1'b0;
    data_b = 16'h0;
    bad_clk = 0;
    bad_dat = 0;
    for (int i = 0; i < 32; i++) begin
      if (sclk_b !== 1'(i % 2)) bad_clk++;
      if (dat_b !== (i < 2)) bad_dat++;
      @(negedge clk);
    end
    check("clk_b_toggle", bad_clk, 0);
    check("dat_b_msb_only", bad_dat, 0);
    repeat (4) @(negedge clk);
    check("busy_b_idle", {busy_b, err_b}, 0);

    repeat (5) @(negedge clk);
    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
